// File: rtl/piccolo_pkg.sv
// rtl/piccolo_pkg.sv - shared Piccolo primitives: S-box, GF(2^4) math, F, RP, constants, key-word permutation
package piccolo_pkg;

   localparam int ROUNDS80  = 25;
   localparam int ROUNDS128 = 31;

   // Masks folded into the round-constant pattern for each key size
   localparam logic [31:0] CON80_MASK  = 32'h0f1e2d3c;
   localparam logic [31:0] CON128_MASK = 32'h6547a98b;

   typedef enum logic [1:0] {IDLE, RUN, FIN} dec_state_t;

   function automatic logic [3:0] sbox(input logic [3:0] a);
      logic [3:0] r;
      r = 4'h0;
      case (a)
         4'h0: r = 4'he;
         4'h1: r = 4'h4;
         4'h2: r = 4'hb;
         4'h3: r = 4'h2;
         4'h4: r = 4'h3;
         4'h5: r = 4'h8;
         4'h6: r = 4'h0;
         4'h7: r = 4'h9;
         4'h8: r = 4'h1;
         4'h9: r = 4'ha;
         4'ha: r = 4'h7;
         4'hb: r = 4'hf;
         4'hc: r = 4'h6;
         4'hd: r = 4'hc;
         4'he: r = 4'h5;
         4'hf: r = 4'hd;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   // Multiply by x modulo x^4 + x + 1
   function automatic logic [3:0] xtime(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
   endfunction

   // S-layer, diffusion matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2], S-layer
   function automatic logic [15:0] f_func(input logic [15:0] x);
      logic [3:0] s0, s1, s2, s3;
      logic [3:0] y0, y1, y2, y3;
      s0 = sbox(x[15:12]);
      s1 = sbox(x[11:8]);
      s2 = sbox(x[7:4]);
      s3 = sbox(x[3:0]);
      y0 = xtime(s0) ^ (xtime(s1) ^ s1) ^ s2 ^ s3;
      y1 = s0 ^ xtime(s1) ^ (xtime(s2) ^ s2) ^ s3;
      y2 = s0 ^ s1 ^ xtime(s2) ^ (xtime(s3) ^ s3);
      y3 = (xtime(s0) ^ s0) ^ s1 ^ s2 ^ xtime(s3);
      return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
   endfunction

   // Byte map (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5), x0 = most significant byte
   function automatic logic [63:0] rp(input logic [63:0] x);
      return {x[47:40], x[7:0], x[31:24], x[55:48],
              x[15:8], x[39:32], x[63:56], x[23:16]};
   endfunction

   // Round-constant pair for round i: {con_2i, con_2i+1}
   function automatic logic [31:0] con_pair(input logic [4:0] i, input logic [31:0] mask);
      logic [4:0] c;
      c = i + 5'd1;
      return {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ mask;
   endfunction

   // Source key word for position pos after n applications of the 128-bit
   // key-word permutation (k2,k1,k6,k7,k0,k3,k4,k5); the permutation has order 12.
   function automatic logic [2:0] sigma_idx(input logic [3:0] n, input logic [2:0] pos);
      logic [23:0] t;
      case (n)
         4'd0:    t = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
         4'd1:    t = {3'd2, 3'd1, 3'd6, 3'd7, 3'd0, 3'd3, 3'd4, 3'd5};
         4'd2:    t = {3'd6, 3'd1, 3'd4, 3'd5, 3'd2, 3'd7, 3'd0, 3'd3};
         4'd3:    t = {3'd4, 3'd1, 3'd0, 3'd3, 3'd6, 3'd5, 3'd2, 3'd7};
         4'd4:    t = {3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd3, 3'd6, 3'd5};
         4'd5:    t = {3'd2, 3'd1, 3'd6, 3'd5, 3'd0, 3'd7, 3'd4, 3'd3};
         4'd6:    t = {3'd6, 3'd1, 3'd4, 3'd3, 3'd2, 3'd5, 3'd0, 3'd7};
         4'd7:    t = {3'd4, 3'd1, 3'd0, 3'd7, 3'd6, 3'd3, 3'd2, 3'd5};
         4'd8:    t = {3'd0, 3'd1, 3'd2, 3'd5, 3'd4, 3'd7, 3'd6, 3'd3};
         4'd9:    t = {3'd2, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd4, 3'd7};
         4'd10:   t = {3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd3, 3'd0, 3'd5};
         4'd11:   t = {3'd4, 3'd1, 3'd0, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
         default: t = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      endcase
      case (pos)
         3'd0:    return t[23:21];
         3'd1:    return t[20:18];
         3'd2:    return t[17:15];
         3'd3:    return t[14:12];
         3'd4:    return t[11:9];
         3'd5:    return t[8:6];
         3'd6:    return t[5:3];
         default: return t[2:0];
      endcase
   endfunction

   // Whitening keys packed {wk0, wk1, wk2, wk3}; key word k0 is key[127:112]
   function automatic logic [63:0] whitening(input logic [127:0] key, input logic version);
      logic [15:0] k0, k1, k4, kx;
      k0 = key[127:112];
      k1 = key[111:96];
      k4 = key[63:48];
      kx = version ? key[15:0] : key[79:64];
      return {k0[15:8], k1[7:0], k1[15:8], k0[7:0],
              k4[15:8], kx[7:0], kx[15:8], k4[7:0]};
   endfunction

endpackage

// File: rtl/piccolo_rk_gen.sv
// rtl/piccolo_rk_gen.sv - combinational forward round-key pair generator for Piccolo-80/128
// Ports:
//   round_idx  in  5    forward round index i
//   version    in  1    0 = Piccolo-80, 1 = Piccolo-128
//   key        in  128  key, word k0 in [127:112]; Piccolo-80 uses [127:48]
//   rk_even    out 16   rk_2i
//   rk_odd     out 16   rk_2i+1
module piccolo_rk_gen
   import piccolo_pkg::*;
(
   input  logic [4:0]   round_idx,
   input  logic         version,
   input  logic [127:0] key,
   output logic [15:0]  rk_even,
   output logic [15:0]  rk_odd
);

   logic [15:0] kw [8];
   logic [31:0] con;
   logic [4:0]  idx_p1;
   logic [3:0]  perm_n;
   logic [2:0]  pos_e;
   logic [2:0]  pos_o;
   logic [2:0]  mod5;

   always_comb begin
      for (int w = 0; w < 8; w++) begin
         kw[w] = key[127 - 16*w -: 16];
      end
   end

   // 128-bit schedule: rk_m uses word (m+2) mod 8 after floor((m+2)/8)
   // permutations; for m = 2i this is position 2(i+1) mod 8 after (i+1)/4 steps.
   assign idx_p1 = round_idx + 5'd1;
   assign perm_n = {1'b0, idx_p1[4:2]};
   assign pos_e  = {idx_p1[1:0], 1'b0};
   assign pos_o  = {idx_p1[1:0], 1'b1};
   assign mod5   = 3'(round_idx % 5'd5);
   assign con    = con_pair(round_idx, version ? CON128_MASK : CON80_MASK);

   always_comb begin
      rk_even = 16'h0;
      rk_odd  = 16'h0;
      if (version) begin
         rk_even = kw[sigma_idx(perm_n, pos_e)] ^ con[31:16];
         rk_odd  = kw[sigma_idx(perm_n, pos_o)] ^ con[15:0];
      end else begin
         case (mod5)
            3'd0, 3'd2: begin
               rk_even = kw[2] ^ con[31:16];
               rk_odd  = kw[3] ^ con[15:0];
            end
            3'd1, 3'd4: begin
               rk_even = kw[0] ^ con[31:16];
               rk_odd  = kw[1] ^ con[15:0];
            end
            default: begin
               rk_even = kw[4] ^ con[31:16];
               rk_odd  = kw[4] ^ con[15:0];
            end
         endcase
      end
   end

endmodule

// File: rtl/piccolo_dec.sv
// rtl/piccolo_dec.sv - iterative Piccolo-80/128 decryption core, one round per clock
// Ports:
//   clk         in  1    rising-edge clock
//   reset       in  1    asynchronous active-high reset
//   start       in  1    request, accepted when ready=1
//   version     in  1    0 = Piccolo-80 (25 rounds), 1 = Piccolo-128 (31 rounds)
//   key_in      in  128  key, first key bit at [127]
//   ciphertext  in  64   ciphertext, first bit at [63]
//   ready       out 1    idle, start will be accepted
//   done        out 1    one-cycle pulse, plaintext valid
//   plaintext   out 64   result, held until the next accepted start
module piccolo_dec
   import piccolo_pkg::*;
#(
   parameter int ROUNDS80  = piccolo_pkg::ROUNDS80,
   parameter int ROUNDS128 = piccolo_pkg::ROUNDS128
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         version,
   input  logic [127:0] key_in,
   input  logic [63:0]  ciphertext,
   output logic         ready,
   output logic         done,
   output logic [63:0]  plaintext
);

   dec_state_t   state_q, state_d;
   logic [63:0]  x_q;
   logic [4:0]   j_q;
   logic         ver_q;
   logic [127:0] key_q;

   logic [4:0]   last_j;
   logic [4:0]   fwd_idx;
   logic         last_round;
   logic [15:0]  rk_even, rk_odd;
   logic [15:0]  rk_a, rk_b;
   logic [63:0]  wk_in, wk_q;
   logic [63:0]  round_out;

   assign ready      = (state_q == IDLE);
   assign last_j     = ver_q ? 5'(ROUNDS128 - 1) : 5'(ROUNDS80 - 1);
   assign last_round = (j_q == last_j);
   // Decryption round j consumes the forward key pair of round R-1-j
   assign fwd_idx    = last_j - j_q;

   piccolo_rk_gen u_rk_gen (
      .round_idx (fwd_idx),
      .version   (ver_q),
      .key       (key_q),
      .rk_even   (rk_even),
      .rk_odd    (rk_odd)
   );

   // Decryption reuses the forward RP; on odd rounds the state halves sit
   // swapped relative to encryption, so the key pair swaps with them.
   assign rk_a = j_q[0] ? rk_odd  : rk_even;
   assign rk_b = j_q[0] ? rk_even : rk_odd;

   assign wk_in = whitening(key_in, version);
   assign wk_q  = whitening(key_q, ver_q);

   always_comb begin
      round_out        = x_q;
      round_out[47:32] = x_q[47:32] ^ f_func(x_q[63:48]) ^ rk_a;
      round_out[15:0]  = x_q[15:0]  ^ f_func(x_q[31:16]) ^ rk_b;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_round) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= 64'h0;
         j_q       <= 5'd0;
         ver_q     <= 1'b0;
         key_q     <= 128'h0;
         done      <= 1'b0;
         plaintext <= 64'h0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == FIN);
         case (state_q)
            IDLE: begin
               if (start) begin
                  ver_q <= version;
                  key_q <= key_in;
                  x_q   <= {ciphertext[63:48] ^ wk_in[31:16], ciphertext[47:32],
                            ciphertext[31:16] ^ wk_in[15:0],  ciphertext[15:0]};
                  j_q   <= 5'd0;
               end
            end
            RUN: begin
               x_q <= last_round ? round_out : rp(round_out);
               j_q <= j_q + 5'd1;
            end
            FIN: begin
               plaintext <= {x_q[63:48] ^ wk_q[63:48], x_q[47:32],
                             x_q[31:16] ^ wk_q[47:32], x_q[15:0]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piccolo_dec.sv
// tb/tb_piccolo_dec.sv - self-checking bench for piccolo_dec against a forward-encryption model
module tb_piccolo_dec;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         version;
   logic [127:0] key_in;
   logic [63:0]  ciphertext;
   logic         ready;
   logic         done;
   logic [63:0]  plaintext;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piccolo_dec dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .version    (version),
      .key_in     (key_in),
      .ciphertext (ciphertext),
      .ready      (ready),
      .done       (done),
      .plaintext  (plaintext)
   );

   localparam logic [3:0] SB [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                      4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
   localparam int MIX [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
   localparam int RPM [8]    = '{2, 7, 4, 1, 6, 3, 0, 5};

   function automatic logic [3:0] gmul(input logic [3:0] a, input int b);
      logic [3:0] p;
      logic [3:0] aa;
      p  = 4'h0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p ^= aa;
         aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [15:0] m_f(input logic [15:0] x);
      logic [3:0] s [4];
      logic [3:0] y [4];
      for (int i = 0; i < 4; i++) s[i] = SB[x[15 - 4*i -: 4]];
      for (int r = 0; r < 4; r++) begin
         y[r] = 4'h0;
         for (int c = 0; c < 4; c++) y[r] ^= gmul(s[c], MIX[r][c]);
      end
      return {SB[y[0]], SB[y[1]], SB[y[2]], SB[y[3]]};
   endfunction

   // Forward Piccolo encryption straight from the algorithm description
   function automatic logic [63:0] m_encrypt(input logic [127:0] key, input logic ver,
                                             input logic [63:0] pt);
      logic [15:0] k [8];
      logic [15:0] t [8];
      logic [15:0] rk [62];
      logic [15:0] con [62];
      logic [15:0] wk [4];
      logic [15:0] x [4];
      logic [7:0]  b [8];
      logic [63:0] v;
      logic [31:0] cp;
      logic [4:0]  c5;
      int r;
      for (int w = 0; w < 8; w++) k[w] = key[127 - 16*w -: 16];
      r = ver ? 31 : 25;
      wk[0] = {k[0][15:8], k[1][7:0]};
      wk[1] = {k[1][15:8], k[0][7:0]};
      if (ver) begin
         wk[2] = {k[4][15:8], k[7][7:0]};
         wk[3] = {k[7][15:8], k[4][7:0]};
      end else begin
         wk[2] = {k[4][15:8], k[3][7:0]};
         wk[3] = {k[3][15:8], k[4][7:0]};
      end
      for (int i = 0; i < r; i++) begin
         c5 = 5'(i + 1);
         cp = {c5, 5'd0, c5, 2'b00, c5, 5'd0, c5} ^ (ver ? 32'h6547a98b : 32'h0f1e2d3c);
         con[2*i]   = cp[31:16];
         con[2*i+1] = cp[15:0];
      end
      if (!ver) begin
         for (int i = 0; i < r; i++) begin
            case (i % 5)
               0, 2:    begin rk[2*i] = k[2]; rk[2*i+1] = k[3]; end
               1, 4:    begin rk[2*i] = k[0]; rk[2*i+1] = k[1]; end
               default: begin rk[2*i] = k[4]; rk[2*i+1] = k[4]; end
            endcase
            rk[2*i]   ^= con[2*i];
            rk[2*i+1] ^= con[2*i+1];
         end
      end else begin
         for (int m = 0; m < 2*r; m++) begin
            if ((m + 2) % 8 == 0) begin
               t = k;
               k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
               k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
            end
            rk[m] = k[(m + 2) % 8] ^ con[m];
         end
      end
      for (int w = 0; w < 4; w++) x[w] = pt[63 - 16*w -: 16];
      x[0] ^= wk[0];
      x[2] ^= wk[1];
      for (int i = 0; i < r; i++) begin
         x[1] ^= m_f(x[0]) ^ rk[2*i];
         x[3] ^= m_f(x[2]) ^ rk[2*i+1];
         if (i < r - 1) begin
            v = {x[0], x[1], x[2], x[3]};
            for (int q = 0; q < 8; q++) b[q] = v[63 - 8*RPM[q] -: 8];
            v = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
            for (int w = 0; w < 4; w++) x[w] = v[63 - 16*w -: 16];
         end
      end
      x[0] ^= wk[2];
      x[2] ^= wk[3];
      return {x[0], x[1], x[2], x[3]};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Launch one operation, scramble inputs while it runs, wait (bounded) for done
   task automatic run_op(input logic v, input logic [127:0] k, input logic [63:0] c,
                         output logic [63:0] pt, output int lat);
      @(negedge clk);
      version = v; key_in = k; ciphertext = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      version = 1'($urandom()); key_in = rand128(); ciphertext = rand64();
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      pt = plaintext;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++;
      if (plaintext !== 64'h0) begin n_fail++; $display("FAIL reset_plaintext: got %h expected 0", plaintext); end
      reset = 1'b0;
   endtask

   task automatic test_kat80();
      logic [63:0] pt;
      int lat;
      run_op(1'b0, {80'h00112233445566778899, 48'h0}, 64'h8d2bff9935f84056, pt, lat);
      n_checks++;
      if (pt !== 64'h0123456789abcdef) begin n_fail++; $display("FAIL kat80_pt: got %h expected 0123456789abcdef", pt); end
      n_checks++;
      if (lat !== 26) begin n_fail++; $display("FAIL kat80_latency: got %0d expected 26", lat); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL kat80_done_pulse: got %b expected 0", done); end
      n_checks++;
      if (plaintext !== 64'h0123456789abcdef) begin n_fail++; $display("FAIL kat80_hold: got %h expected 0123456789abcdef", plaintext); end
   endtask

   task automatic test_kat128();
      logic [127:0] k;
      logic [63:0]  pt;
      int lat;
      k = 128'h00112233445566778899aabbccddeeff;
      run_op(1'b1, k, m_encrypt(k, 1'b1, 64'h0123456789abcdef), pt, lat);
      n_checks++;
      if (pt !== 64'h0123456789abcdef) begin n_fail++; $display("FAIL kat128_pt: got %h expected 0123456789abcdef", pt); end
      n_checks++;
      if (lat !== 32) begin n_fail++; $display("FAIL kat128_latency: got %0d expected 32", lat); end
   endtask

   task automatic test_version_switch();
      logic [127:0] k;
      logic [63:0]  p, pt;
      int lat;
      k = rand128();
      p = rand64();
      run_op(1'b0, {k[127:48], 48'h0}, m_encrypt({k[127:48], 48'h0}, 1'b0, p), pt, lat);
      n_checks++;
      if (pt !== p || lat !== 26) begin n_fail++; $display("FAIL vswitch_80: got %h/%0d expected %h/26", pt, lat, p); end
      run_op(1'b1, k, m_encrypt(k, 1'b1, p), pt, lat);
      n_checks++;
      if (pt !== p || lat !== 32) begin n_fail++; $display("FAIL vswitch_128: got %h/%0d expected %h/32", pt, lat, p); end
      // Garbage in the unused key tail must not change a Piccolo-80 result
      run_op(1'b0, {k[127:48], ~k[47:0]}, m_encrypt({k[127:48], 48'h0}, 1'b0, p), pt, lat);
      n_checks++;
      if (pt !== p || lat !== 26) begin n_fail++; $display("FAIL vswitch_80_tail: got %h/%0d expected %h/26", pt, lat, p); end
   endtask

   task automatic test_random();
      logic [127:0] k;
      logic [63:0]  p, pt;
      logic         v;
      int lat;
      for (int n = 0; n < 400; n++) begin
         v = 1'(n % 2);
         k = rand128();
         p = rand64();
         run_op(v, k, m_encrypt(k, v, p), pt, lat);
         n_checks++;
         if (pt !== p) begin n_fail++; $display("FAIL random_pt[%0d] v=%b: got %h expected %h", n, v, pt, p); end
         n_checks++;
         if (lat !== (v ? 32 : 26)) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, lat, v ? 32 : 26); end
      end
   endtask

   task automatic test_busy();
      logic [127:0] k;
      logic [63:0]  p, pt;
      int ndone, dlat;
      k = rand128();
      p = rand64();
      ndone = 0; dlat = -1; pt = 64'h0;
      @(negedge clk);
      version = 1'b1; key_in = k; ciphertext = m_encrypt(k, 1'b1, p); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int lat = 1; lat <= 38; lat++) begin
         @(negedge clk);
         if (done) begin ndone++; dlat = lat; pt = plaintext; end
         if (lat == 5 || lat == 20) begin
            start = 1'b1; version = 1'b0; key_in = rand128(); ciphertext = rand64();
         end else begin
            start = 1'b0;
         end
         if (lat == 10) ciphertext = rand64();
      end
      n_checks++;
      if (ndone !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
      n_checks++;
      if (dlat !== 32) begin n_fail++; $display("FAIL busy_latency: got %0d expected 32", dlat); end
      n_checks++;
      if (pt !== p) begin n_fail++; $display("FAIL busy_pt: got %h expected %h", pt, p); end
      n_checks++;
      if (plaintext !== p) begin n_fail++; $display("FAIL busy_hold: got %h expected %h", plaintext, p); end
   endtask

   task automatic test_back_to_back(input logic v);
      logic [127:0] k;
      logic [63:0]  pa, pb;
      int r, ndone;
      int dl [2];
      logic [63:0] dp [2];
      r = v ? 31 : 25;
      k = rand128();
      pa = rand64();
      pb = rand64();
      ndone = 0;
      dl[0] = -1; dl[1] = -1; dp[0] = 64'h0; dp[1] = 64'h0;
      @(negedge clk);
      version = v; key_in = k; ciphertext = m_encrypt(k, v, pa); start = 1'b1;
      @(negedge clk);
      ciphertext = m_encrypt(k, v, pb);
      for (int lat = 1; lat <= 2*r + 6; lat++) begin
         @(negedge clk);
         if (done) begin
            if (ndone < 2) begin dl[ndone] = lat; dp[ndone] = plaintext; end
            ndone++;
         end
         if (lat == r + 1) begin
            n_checks++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle v=%b: got %b expected 1", v, ready); end
         end
         if (lat == r + 2) begin
            n_checks++;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept v=%b: ready %b expected 0", v, ready); end
            start = 1'b0;
         end
      end
      n_checks++;
      if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count v=%b: got %0d expected 2", v, ndone); end
      n_checks++;
      if (dl[0] !== r + 1 || dp[0] !== pa) begin n_fail++; $display("FAIL b2b_first v=%b: got %0d/%h expected %0d/%h", v, dl[0], dp[0], r + 1, pa); end
      n_checks++;
      if (dl[1] !== 2*r + 3 || dp[1] !== pb) begin n_fail++; $display("FAIL b2b_second v=%b: got %0d/%h expected %0d/%h", v, dl[1], dp[1], 2*r + 3, pb); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] k;
      logic [63:0]  p, pt;
      int ndone, lat;
      k = rand128();
      p = rand64();
      @(negedge clk);
      version = 1'b0; key_in = k; ciphertext = m_encrypt(k, 1'b0, p); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", ready); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
      n_checks++;
      if (plaintext !== 64'h0) begin n_fail++; $display("FAIL midreset_plaintext: got %h expected 0", plaintext); end
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_checks++;
      if (ndone !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", ndone); end
      run_op(1'b0, k, m_encrypt(k, 1'b0, p), pt, lat);
      n_checks++;
      if (pt !== p || lat !== 26) begin n_fail++; $display("FAIL midreset_next_op: got %h/%0d expected %h/26", pt, lat, p); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; version = 1'b0; key_in = 128'h0; ciphertext = 64'h0;
      test_reset();
      test_kat80();
      test_kat128();
      test_version_switch();
      test_random();
      test_busy();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
